mcycle_unit: RTL and testbench
==============================

# mcycle_unit

Iterative multi-cycle multiply/divide responder that receives the conditioned `M_Start` request from the core's condition logic. It computes signed or unsigned WIDTH×WIDTH multiply or WIDTH/WIDTH divide, one bit per cycle. It holds `Busy` high so the pipeline stalls until the results are ready for write-back. One instance sits beside the ALU in the execute stage.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥4)
- `CLK`  in  1  clock; all state updates on rising edge
- `RESETn`  in  1  asynchronous, active-low reset
- `Start`  in  1  request; driven by the core's `M_Start` (already condition-qualified)
- `MCycleOp`  in  2  [0]: 0 = multiply, 1 = divide; [1]: 0 = signed, 1 = unsigned
- `Operand1`  in  WIDTH  multiplicand / dividend
- `Operand2`  in  WIDTH  multiplier / divisor
- `Result1`  out  WIDTH  multiply: product[WIDTH-1:0]; divide: quotient
- `Result2`  out  WIDTH  multiply: product[2*WIDTH-1:WIDTH]; divide: remainder
- `Busy`  out  1  stall request to the core
- `Done`  out  1  one-cycle pulse; results valid

## Operation
- FSM states: IDLE, COMPUTE, DONE. Reset state is IDLE.
- **IDLE**
  - `Busy = Start`. This is a combinational path, so the stall takes effect in the request cycle.
  - On `Start`=1, latch op, signedness and operands; clear the iteration counter; go to COMPUTE.
- **COMPUTE**
  - `Busy`=1. One iteration per cycle for exactly WIDTH cycles, then go to DONE.
  - `Start` is ignored while in COMPUTE. Operand inputs are ignored after latching.
- **DONE**
  - `Busy`=0 and `Done`=1 for one cycle. `Result1`/`Result2` are valid from this cycle onward.
  - Next state is IDLE.
  - `Result1`/`Result2` hold their values until the next accepted `Start` begins overwriting internal registers. A held value must not change before the next DONE.
- **Signed handling**
  - For signed ops, operate on magnitudes and apply sign correction in the final cycle.
  - Product sign = sign(Op1) XOR sign(Op2).
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
- **Multiply:** shift-add, 2·WIDTH-bit accumulator, full-width product.
- **Divide:** restoring (or non-restoring) shift-subtract, one quotient bit per cycle.
- **Divide by zero** (Operand2 = 0), either signedness:
  - `Result1` = all ones.
  - `Result2` = Operand1 exactly as latched, with no sign correction.
- **Signed overflow:** −2^(WIDTH−1) / −1 gives `Result1` = 0x8000_0000 (WIDTH=32) and `Result2` = 0. No trap, no flag.
- **Reset (any state, including mid-COMPUTE):**
  - Immediately go to IDLE.
  - `Busy`=0 apart from the combinational `Start` term, `Done`=0.
  - `Result1`=`Result2`=0; internal counter and accumulators cleared.
- This block produces no condition flags. The core does not update NZCV from multi-cycle ops.

## Timing
- **Cycle 0:** `Start`=1 in IDLE, so `Busy`=1 combinationally.
- **Cycles 1..WIDTH:** COMPUTE, `Busy`=1.
- **Cycle WIDTH+1:** DONE, `Busy`=0, `Done`=1, results valid.
- Net effect: `Busy` is high for WIDTH+1 consecutive cycles per request. Latency from `Start` to `Done` is WIDTH+1 cycles.
- The core completes the instruction in the DONE cycle (write-back of `Result1`) and advances PC on the next edge.
- A new `Start` is accepted no earlier than the cycle after DONE. Back-to-back ops therefore cost WIDTH+2 cycles each.
- If `Start` is still high in the DONE cycle, it is ignored.
- Reset outputs: `Busy`=0 (with `Start`=0), `Done`=0, `Result1`=0, `Result2`=0.

## Test plan
- **Unsigned multiply.** Op=10, Op1=0xFFFF_FFFF, Op2=0x0000_0002, WIDTH=32. Expect Result1=0xFFFF_FFFE and Result2=0x0000_0001. Expect `Busy` high for exactly 33 cycles and `Done` pulsing in cycle 33.
- **Signed multiply.** Op=00, Op1=−3 (0xFFFF_FFFD), Op2=7. Expect Result1=0xFFFF_FFEB (−21) and Result2=0xFFFF_FFFF.
- **Signed divide.** Op=01, Op1=−7, Op2=2. Expect Result1=0xFFFF_FFFD (−3) and Result2=0xFFFF_FFFF (−1).
- **Unsigned divide.** Op=11, Op1=100, Op2=7. Expect Result1=14 and Result2=2.
- **Divide corner cases:**
  - Op=01, Op1=−7, Op2=0: expect Result1=0xFFFF_FFFF and Result2=0xFFFF_FFF9.
  - Op=01, Op1=0x8000_0000, Op2=−1: expect Result1=0x8000_0000 and Result2=0.
- **Reset and Start-during-COMPUTE.**
  - Assert `RESETn`=0 at cycle 10 of a COMPUTE. Expect `Busy`, `Done` and results to go to 0 immediately.
  - After release, issue a fresh 100/7 divide. Expect correct results after 33 cycles.
  - Toggling `Start` during COMPUTE must not change latency or results.

Source files
------------

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring shift-subtract, one bit per
// cycle, working on operand magnitudes and fixing signs in the last cycle.
// Busy stalls the pipeline from the request cycle until the DONE cycle.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             stateReg;
  logic [CW-1:0]      countReg;
  logic               isDivReg;     // 1 = divide, 0 = multiply
  logic               negLoReg;     // negate product / quotient at the end
  logic               negHiReg;     // negate remainder at the end
  logic               divZeroReg;   // divisor was zero when latched
  logic [WIDTH-1:0]   operandReg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   op1RawReg;    // dividend as presented, for divide by zero
  logic [WIDTH-1:0]   result1Reg;
  logic [WIDTH-1:0]   result2Reg;
  logic               doneReg;
  // Shared accumulator: multiply {partial product, multiplier};
  // divide {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] accReg;
  logic [2*WIDTH-1:0] accNext;

  // Request-side operand conditioning (magnitudes and sign flags)
  logic             isSigned;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign isSigned = ~MCycleOp[1];
  assign neg1     = isSigned & Operand1[WIDTH-1];
  assign neg2     = isSigned & Operand2[WIDTH-1];
  assign mag1     = neg1 ? -Operand1 : Operand1;
  assign mag2     = neg2 ? -Operand2 : Operand2;

  // Datapath terms for one iteration
  logic [WIDTH:0] mulSum;
  logic [WIDTH:0] remShift;
  logic [WIDTH:0] divDiff;

  assign mulSum   = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, operandReg} : '0);
  assign remShift = accReg[2*WIDTH-1:WIDTH-1];
  assign divDiff  = remShift - {1'b0, operandReg};

  // One shift-add or shift-subtract step of the accumulator
  always_comb begin
    if (!isDivReg) begin
      accNext = {mulSum, accReg[WIDTH-1:1]};
    end else if (!divDiff[WIDTH]) begin
      accNext = {divDiff[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};
    end else begin
      accNext = {accReg[2*WIDTH-2:0], 1'b0};
    end
  end

  // Final sign correction and divide-by-zero override applied to the last step
  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   res1Next;
  logic [WIDTH-1:0]   res2Next;

  always_comb begin
    prodFinal = negLoReg ? -accNext : accNext;
    res1Next  = prodFinal[WIDTH-1:0];
    res2Next  = prodFinal[2*WIDTH-1:WIDTH];
    if (isDivReg) begin
      if (divZeroReg) begin
        res1Next = '1;
        res2Next = op1RawReg;
      end else begin
        res1Next = negLoReg ? -accNext[WIDTH-1:0] : accNext[WIDTH-1:0];
        res2Next = negHiReg ? -accNext[2*WIDTH-1:WIDTH] : accNext[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Control FSM with registered results and Done pulse
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      isDivReg   <= 1'b0;
      negLoReg   <= 1'b0;
      negHiReg   <= 1'b0;
      divZeroReg <= 1'b0;
      operandReg <= '0;
      op1RawReg  <= '0;
      accReg     <= '0;
      result1Reg <= '0;
      result2Reg <= '0;
      doneReg    <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          doneReg <= 1'b0;
          if (Start) begin
            isDivReg   <= MCycleOp[0];
            negLoReg   <= neg1 ^ neg2;
            negHiReg   <= neg1;
            divZeroReg <= (Operand2 == '0);
            op1RawReg  <= Operand1;
            operandReg <= MCycleOp[0] ? mag2 : mag1;
            accReg     <= {{WIDTH{1'b0}}, (MCycleOp[0] ? mag1 : mag2)};
            countReg   <= '0;
            stateReg   <= COMPUTE;
          end
        end
        COMPUTE: begin
          accReg   <= accNext;
          countReg <= countReg + CW'(1);
          if (countReg == CW'(WIDTH - 1)) begin
            result1Reg <= res1Next;
            result2Reg <= res2Next;
            doneReg    <= 1'b1;
            stateReg   <= DONE;
          end
        end
        DONE: begin
          doneReg  <= 1'b0;
          stateReg <= IDLE;
        end
        default: begin
          doneReg  <= 1'b0;
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the request cycle combinationally, then all of COMPUTE
  assign Busy    = (stateReg == COMPUTE) | ((stateReg == IDLE) & Start);
  assign Done    = doneReg;
  assign Result1 = result1Reg;
  assign Result2 = result2Reg;

endmodule

// File: tb/tb_mcycle_unit.sv
// Testbench for mcycle_unit: directed operations with literal expectations,
// plus a cycle-by-cycle monitor comparing against an arithmetic model.
module tb_mcycle_unit;

  localparam int WIDTH = 32;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'b00;
  logic [31:0] Operand1 = '0;
  logic [31:0] Operand2 = '0;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;

  int tests = 0;
  int fails = 0;

  mcycle_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .RESETn(RESETn),
    .Start(Start),
    .MCycleOp(MCycleOp),
    .Operand1(Operand1),
    .Operand2(Operand2),
    .Result1(Result1),
    .Result2(Result2),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic model: returns {Result2, Result1}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[0]) begin
      if (op[1]) p = {32'd0, a} * {32'd0, b};
      else       p = sa * sb;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op[1]) return {a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Per-cycle monitor
  bit          inFlight = 1'b0;
  int          k = 0;
  logic [31:0] held1 = '0, held2 = '0, pend1 = '0, pend2 = '0;

  always @(negedge CLK) begin
    if (!RESETn) begin
      check("rst_busy", Busy, Start);
      check("rst_done", Done, 0);
      check("rst_r1", Result1, 0);
      check("rst_r2", Result2, 0);
      inFlight = 1'b0;
      held1 = '0;
      held2 = '0;
    end else if (!inFlight) begin
      check("idle_busy", Busy, Start);
      check("idle_done", Done, 0);
      check("idle_r1", Result1, held1);
      check("idle_r2", Result2, held2);
      if (Start) begin
        {pend2, pend1} = model(MCycleOp, Operand1, Operand2);
        inFlight = 1'b1;
        k = 0;
      end
    end else begin
      k++;
      if (k <= WIDTH) begin
        check("cmp_busy", Busy, 1);
        check("cmp_done", Done, 0);
        check("cmp_r1_hold", Result1, held1);
        check("cmp_r2_hold", Result2, held2);
      end else begin
        check("done_busy", Busy, 0);
        check("done_pulse", Done, 1);
        check("done_r1_model", Result1, pend1);
        check("done_r2_model", Result2, pend2);
        held1 = pend1;
        held2 = pend2;
        inFlight = 1'b0;
      end
    end
  end

  // Issue one op starting now (caller is at posedge+1), wait for Done
  task automatic doOp(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                      input bit toggle);
    int busyCnt;
    int doneAt;
    busyCnt = 0;
    doneAt = -1;
    Start = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    for (int c = 0; c < 100 && doneAt < 0; c++) begin
      @(negedge CLK);
      if (Busy) busyCnt++;
      if (Done) doneAt = c;
      @(posedge CLK);
      #1;
      if (toggle) Start = (c < 25) ? 1'($urandom_range(0, 1)) : (c == 32);
      else        Start = 1'b0;
      if (c == 0) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = 2'($urandom);
      end
    end
    if (doneAt < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no Done required Done within 100 cycles", name);
    end
    check({name, "_r1"}, Result1, e1);
    check({name, "_r2"}, Result2, e2);
    check({name, "_busy_cycles"}, busyCnt, WIDTH + 1);
    check({name, "_done_cycle"}, doneAt, WIDTH + 1);
    $display("[TB] %s op=%b a=%h b=%h -> r1=%h r2=%h busy=%0d done@%0d",
             name, op, a, b, Result1, Result2, busyCnt, doneAt);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;

    doOp("umul",   2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    doOp("smul",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    doOp("sdiv",   2'b01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    doOp("udiv",   2'b11, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
    doOp("sdiv0",  2'b01, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    doOp("sovf",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    doOp("udiv0",  2'b11, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    doOp("smulmn", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0);
    doOp("sdivpn", 2'b01, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);

    // Reset in the middle of COMPUTE
    Start = 1'b1;
    MCycleOp = 2'b10;
    Operand1 = 32'hFFFF_FFFF;
    Operand2 = 32'd3;
    repeat (10) begin
      @(posedge CLK);
      #1;
      Start = 1'b0;
    end
    RESETn = 1'b0;
    @(negedge CLK);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_r1", Result1, 0);
    check("midrst_r2", Result2, 0);
    $display("[TB] reset mid-compute -> busy=%b done=%b r1=%h r2=%h", Busy, Done, Result1, Result2);
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // Fresh divide with Start toggling during COMPUTE and held high in DONE
    doOp("udiv_tog", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    Start = 1'b0;
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
